// File: rtl/rvcpu_mem_responder.sv
// Memory-side responder for the RV64I core: on-chip 64-bit SRAM plus CLINT mtime/mtimecmp.
// Latency: mem_data_ready pulses LATENCY cycles after the request is first seen in IDLE.
// Backpressure: none; one transaction at a time, enables held by the core until the ready pulse.
//
// Ports:
//   clk, rst (async, active-low)
//   r_mem_ena / w_mem_ena   read / write request (write wins if both high)
//   rw_mem_addr [63:0]      byte address
//   rw_mem_bytes [2:0]      funct3 size/sign code (B,H,W,D,BU,HU,WU)
//   w_mem_data [63:0]       right-aligned store data
//   mem_data_ready          one-cycle completion pulse
//   mem_data [63:0]         registered, extended, right-aligned read data (held until next response)
//   mtime_intr              level timer interrupt, registered (mtime >= mtimecmp)
module rvcpu_mem_responder #(
    parameter int          MEM_DEPTH = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 2,
    parameter int          TIMER_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_mem_ena,
    input  logic        w_mem_ena,
    input  logic [63:0] rw_mem_addr,
    input  logic [2:0]  rw_mem_bytes,
    input  logic [63:0] w_mem_data,
    output logic        mem_data_ready,
    output logic [63:0] mem_data,
    output logic        mtime_intr
);

    localparam int          IDX_W         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [63:0] SRAM_BYTES    = 64'(MEM_DEPTH) << 3;
    localparam int          CNT_W         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int          DIV_W         = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TIMER_DIV - 1);
    localparam logic [63:0] MTIMECMP_ADDR = 64'h0000_0000_0200_4000;
    localparam logic [63:0] MTIME_ADDR    = 64'h0000_0000_0200_BFF8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;

    // Latched transaction
    logic [63:0]       r_addr;
    logic [63:0]       r_wdata;
    logic [2:0]        r_bytes;
    logic              r_is_wr;

    logic [63:0]       r_mem [MEM_DEPTH];
    logic [63:0]       r_rdata;

    logic [63:0]       r_mtime;
    logic [63:0]       r_mtimecmp;
    logic [DIV_W-1:0]  r_div;
    logic              r_intr;

    logic              w_req;
    logic              w_idle;
    logic [63:0]       w_addr;
    logic [63:0]       w_wdata;
    logic [2:0]        w_bytes;
    logic              w_is_wr;
    logic [63:0]       w_rel;
    logic              w_hit_sram;
    logic              w_hit_cmp;
    logic              w_hit_time;
    logic [IDX_W-1:0]  w_idx;
    logic [2:0]        w_off;
    logic [5:0]        w_shamt;
    logic [63:0]       w_old;
    logic [7:0]        w_len;
    logic [7:0]        w_lanes;
    logic [63:0]       w_bitmask;
    logic [63:0]       w_merged;
    logic [63:0]       w_shifted;
    logic [63:0]       w_rdext;
    logic              w_commit;
    logic              w_tick;

    assign w_req  = r_mem_ena | w_mem_ena;
    assign w_idle = (r_state == S_IDLE);

    // In IDLE the decode looks at the live request so LATENCY=1 can respond on
    // the very next edge; afterwards it uses the latched copy.
    assign w_addr  = w_idle ? rw_mem_addr  : r_addr;
    assign w_wdata = w_idle ? w_mem_data   : r_wdata;
    assign w_bytes = w_idle ? rw_mem_bytes : r_bytes;
    assign w_is_wr = w_idle ? w_mem_ena    : r_is_wr;

    // Address decode; timer registers match on the 8-byte word so sub-word
    // accesses go through the same lane logic as SRAM.
    assign w_rel      = w_addr - BASE_ADDR;
    assign w_hit_sram = (w_addr >= BASE_ADDR) && (w_rel < SRAM_BYTES);
    assign w_idx      = w_rel[IDX_W+2:3];
    assign w_hit_cmp  = (w_addr[63:3] == MTIMECMP_ADDR[63:3]);
    assign w_hit_time = (w_addr[63:3] == MTIME_ADDR[63:3]);
    assign w_off      = w_addr[2:0];
    assign w_shamt    = {w_off, 3'b000};

    always_comb begin
        w_old = 64'd0;
        if (w_hit_sram) begin
            w_old = r_mem[w_idx];
        end else if (w_hit_cmp) begin
            w_old = r_mtimecmp;
        end else if (w_hit_time) begin
            w_old = r_mtime;
        end
    end

    // Byte-lane mask; the 8-bit shift drops lanes past byte 7 (truncation, no wrap).
    always_comb begin
        case (w_bytes[1:0])
            2'b00:   w_len = 8'h01;
            2'b01:   w_len = 8'h03;
            2'b10:   w_len = 8'h0F;
            default: w_len = 8'hFF;
        endcase
    end

    assign w_lanes = w_len << w_off;

    always_comb begin
        w_bitmask = 64'd0;
        for (int i = 0; i < 8; i++) begin
            w_bitmask[i*8 +: 8] = {8{w_lanes[i]}};
        end
    end

    assign w_merged  = (w_old & ~w_bitmask) | ((w_wdata << w_shamt) & w_bitmask);
    assign w_shifted = w_old >> w_shamt;

    always_comb begin
        case (w_bytes)
            3'b000:  w_rdext = {{56{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_rdext = {{48{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_rdext = {{32{w_shifted[31]}}, w_shifted[31:0]};
            3'b100:  w_rdext = {56'd0, w_shifted[7:0]};
            3'b101:  w_rdext = {48'd0, w_shifted[15:0]};
            3'b110:  w_rdext = {32'd0, w_shifted[31:0]};
            default: w_rdext = w_shifted;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                // Counter is loaded with LATENCY-1; leaving when it would hit zero
                // places RESP exactly LATENCY cycles after acceptance.
                if (r_cnt <= CNT_ONE) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        mem_data_ready = (r_state == S_RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_idle && w_req) begin
            r_cnt <= CNT_LOAD;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_bytes <= 3'd0;
            r_is_wr <= 1'b0;
        end else if (w_idle && w_req) begin
            r_addr  <= rw_mem_addr;
            r_wdata <= w_mem_data;
            r_bytes <= rw_mem_bytes;
            r_is_wr <= w_mem_ena;
        end
    end

    // Read data is captured on the edge that enters RESP and held afterwards,
    // since the core consumes it the cycle after the ready pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 64'd0;
        end else if (w_next == S_RESP) begin
            r_rdata <= w_is_wr ? 64'd0 : w_rdext;
        end
    end

    // Stores commit on the edge that ends RESP; a reset before then abandons them.
    assign w_commit = (r_state == S_RESP) && r_is_wr;

    always_ff @(posedge clk) begin
        if (w_commit && w_hit_sram) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_div      <= '0;
            r_intr     <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : (r_div + DIV_W'(1));
            // A software write to mtime overrides that cycle's increment.
            if (w_commit && w_hit_time) begin
                r_mtime <= w_merged;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end
            if (w_commit && w_hit_cmp) begin
                r_mtimecmp <= w_merged;
            end
            r_intr <= (r_mtime >= r_mtimecmp);
        end
    end

    assign mem_data   = r_rdata;
    assign mtime_intr = r_intr;

endmodule
